// File: rtl/bcd_modcnt.sv
// Two-digit BCD modulo counter (0..MODULUS-1) with up/down counting,
// range-checked preset load and a manual adjust input. The ca/bo outputs
// feed the cnten input of the next stage, so a chain of stages all step
// on the same clock edge.
module bcd_modcnt #(
  parameter int MODULUS = 60,
  parameter int UPW     = 3,
  parameter int INIT    = 0
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           cnten,
  input  logic           dir,
  input  logic           load,
  input  logic [UPW-1:0] ldup,
  input  logic [3:0]     ldlow,
  input  logic           adj,
  output logic           ca,
  output logic           bo,
  output logic [UPW-1:0] digitup,
  output logic [3:0]     digitlow,
  output logic           ld_err
);

  // Terminal value MODULUS-1 and reset value INIT, split into BCD digits.
  localparam int TOPUP  = (MODULUS - 1) / 10;
  localparam int TOPLOW = (MODULUS - 1) % 10;

  localparam logic [UPW-1:0] TOPUP_D    = UPW'(TOPUP);
  localparam logic [3:0]     TOPLOW_D   = 4'(TOPLOW);
  localparam logic [UPW-1:0] INIT_UP_D  = UPW'(INIT / 10);
  localparam logic [3:0]     INIT_LOW_D = 4'(INIT % 10);

  // Reject illegal parameter sets while elaborating.
  if (MODULUS < 2 || MODULUS > 100) begin : g_bad_modulus
    $error("bcd_modcnt: MODULUS=%0d outside 2..100", MODULUS);
  end
  if (UPW < 1 || (2 ** UPW) <= TOPUP) begin : g_bad_upw
    $error("bcd_modcnt: UPW=%0d cannot hold upper digit %0d", UPW, TOPUP);
  end
  if (INIT < 0 || INIT >= MODULUS) begin : g_bad_init
    $error("bcd_modcnt: INIT=%0d outside 0..MODULUS-1", INIT);
  end

  logic           at_top;
  logic           at_zero;
  logic           ld_ok;
  logic [UPW-1:0] inc_up,  dec_up,  up_nx;
  logic [3:0]     inc_low, dec_low, low_nx;
  logic           err_nx;

  // Digit-wise range tests; the counter never converts to binary.
  assign at_top  = (digitup == TOPUP_D) && (digitlow == TOPLOW_D);
  assign at_zero = (digitup == '0)      && (digitlow == 4'd0);
  assign ld_ok   = (ldlow <= 4'd9) &&
                   ((ldup < TOPUP_D) || ((ldup == TOPUP_D) && (ldlow <= TOPLOW_D)));

  // Carry/borrow only for a plain count step, so the next stage advances on
  // the same edge that this stage wraps.
  assign ca = cnten & ~dir & ~load & ~adj & ~RST & at_top;
  assign bo = cnten &  dir & ~load & ~adj & ~RST & at_zero;

  // Increment and decrement candidates, both wrapping at the modulus.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    inc_up  = digitup;
    inc_low = digitlow + 4'd1;
    dec_up  = digitup;
    dec_low = digitlow - 4'd1;
    if (at_top) begin
      inc_up  = '0;
      inc_low = 4'd0;
    end else if (digitlow == 4'd9) begin
      inc_up  = digitup + UPW'(1);
      inc_low = 4'd0;
    end
    if (at_zero) begin
      dec_up  = TOPUP_D;
      dec_low = TOPLOW_D;
    end else if (digitlow == 4'd0) begin
      dec_up  = digitup - UPW'(1);
      dec_low = 4'd9;
    end
  end

  // Action select: load beats adj beats cnten; one action per edge.
  always_comb begin
    up_nx  = digitup;
    low_nx = digitlow;
    err_nx = 1'b0;
    if (load) begin
      if (ld_ok) begin
        up_nx  = ldup;
        low_nx = ldlow;
      end else begin
        err_nx = 1'b1;
      end
    end else if (adj) begin
      up_nx  = inc_up;
      low_nx = inc_low;
    end else if (cnten) begin
      up_nx  = dir ? dec_up  : inc_up;
      low_nx = dir ? dec_low : inc_low;
    end
  end

  // Digit and error registers with synchronous reset to INIT.
  always_ff @(posedge CLK) begin
    // NOTE: state registers use non-blocking assignment so every flop
    // samples pre-edge values regardless of statement order.
    if (RST) begin
      digitup  <= INIT_UP_D;
      digitlow <= INIT_LOW_D;
      ld_err   <= 1'b0;
    end else begin
      digitup  <= up_nx;
      digitlow <= low_nx;
      ld_err   <= err_nx;
    end
  end

endmodule
